// File: rtl/mp64_bus_ram_if.sv
// mp64_bus_ram_if: request/response bus between a master and mp64_bus_ram
interface mp64_bus_ram_if;
    logic        bus_valid;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic        bus_wen;
    logic [1:0]  bus_size;
    logic [63:0] bus_rdata;
    logic        bus_ready;
    logic        bus_err;
    modport master(output bus_valid, bus_addr, bus_wdata, bus_wen, bus_size,
                   input bus_rdata, bus_ready, bus_err);
    modport slave(input bus_valid, bus_addr, bus_wdata, bus_wen, bus_size,
                  output bus_rdata, bus_ready, bus_err);
endinterface

// File: rtl/mp64_bus_ram.sv
// mp64_bus_ram: byte-addressed RAM on the mp64 bus with fixed response latency
module mp64_bus_ram #(
    parameter int ADDR_BITS  = 13,
    parameter int LATENCY    = 1,
    parameter int ERR_ON_OOR = 1
) (
    input logic           clk,
    input logic           rst_n,
    mp64_bus_ram_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t               state, state_nx;
    logic [3:0]           cnt, cnt_nx, n;
    logic [63:0]          addr_q, wdata_q, addr_c, wdata_c, rdata_c;
    logic [1:0]           size_q, size_c;
    logic                 wen_q, wen_c, accept, commit, oor;
    logic [ADDR_BITS-1:0] base;
    logic [7:0]           mem [2**ADDR_BITS];

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (bus.bus_valid) begin
                cnt_nx   = 4'(LATENCY - 1);
                state_nx = (LATENCY == 1) ? RESP : WAIT;
            end
            WAIT: begin
                cnt_nx   = cnt - 4'd1;
                state_nx = (cnt == 4'd1) ? RESP : WAIT;
            end
            default: state_nx = IDLE;
        endcase
    end

    // With LATENCY=1 the access commits on the acceptance edge, so use live inputs in IDLE
    always_comb begin
        accept  = (state == IDLE) && bus.bus_valid;
        commit  = rst_n && (state != RESP) && (state_nx == RESP);
        addr_c  = (state == IDLE) ? bus.bus_addr  : addr_q;
        wdata_c = (state == IDLE) ? bus.bus_wdata : wdata_q;
        wen_c   = (state == IDLE) ? bus.bus_wen   : wen_q;
        size_c  = (state == IDLE) ? bus.bus_size  : size_q;
        oor     = (ERR_ON_OOR != 0) && (addr_c[63:ADDR_BITS] != '0);
        base    = addr_c[ADDR_BITS-1:0];
        n       = 4'd1 << size_c;
    end

    always_comb begin
        rdata_c = '0;
        for (int i = 0; i < 8; i++)
            if (4'(i) < n) rdata_c[8*i +: 8] = mem[base + ADDR_BITS'(i)];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wen_q         <= 1'b0;
            size_q        <= '0;
            bus.bus_ready <= 1'b0;
            bus.bus_err   <= 1'b0;
            bus.bus_rdata <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                addr_q  <= bus.bus_addr;
                wdata_q <= bus.bus_wdata;
                wen_q   <= bus.bus_wen;
                size_q  <= bus.bus_size;
            end
            bus.bus_ready <= commit;
            bus.bus_err   <= commit && oor;
            bus.bus_rdata <= (commit && !wen_c && !oor) ? rdata_c : '0;
        end
    end

    always_ff @(posedge clk)
        if (commit && wen_c && !oor)
            for (int i = 0; i < 8; i++)
                if (4'(i) < n) mem[base + ADDR_BITS'(i)] <= wdata_c[8*i +: 8];
endmodule

// File: tb/tb_mp64_bus_ram.sv
// tb_mp64_bus_ram: scoreboard bench driving two RAM instances (LATENCY=1 wrapping, LATENCY=4 erroring)
module tb_mp64_bus_ram;
    logic clk = 1'b0, rst0, rst1;
    always #5 clk = ~clk;

    mp64_bus_ram_if b0(), b1();
    mp64_bus_ram #(.ADDR_BITS(13), .LATENCY(1), .ERR_ON_OOR(0)) u0(.clk(clk), .rst_n(rst0), .bus(b0));
    mp64_bus_ram #(.ADDR_BITS(13), .LATENCY(4), .ERR_ON_OOR(1)) u1(.clk(clk), .rst_n(rst1), .bus(b1));

    typedef struct {logic [63:0] rdata; logic err; int cyc;} exp_t;
    exp_t q0[$], q1[$];
    int cyc = 0, checks = 0, errors = 0;
    logic p0 = 1'b0, p1 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic mon(input string nm, input logic rdy, prv, have, input exp_t e,
                       input logic [63:0] rd, input logic er);
        checks++;
        if (!rdy) begin
            if (rd !== 64'h0 || er !== 1'b0) begin
                errors++;
                $display("FAIL %s idle: rdata=%h err=%b, want 0/0", nm, rd, er);
            end
        end else if (prv) begin
            errors++;
            $display("FAIL %s double_ready at cyc %0d", nm, cyc);
        end else if (!have) begin
            errors++;
            $display("FAIL %s unexpected_response at cyc %0d rdata=%h err=%b", nm, cyc, rd, er);
        end else if (rd !== e.rdata || er !== e.err || cyc != e.cyc) begin
            errors++;
            $display("FAIL %s resp: rdata=%h err=%b cyc=%0d, want rdata=%h err=%b cyc=%0d",
                     nm, rd, er, cyc, e.rdata, e.err, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic have;
        e = '{64'h0, 1'b0, 0};
        have = b0.bus_ready && q0.size() > 0;
        if (have) e = q0.pop_front();
        mon("d0", b0.bus_ready, p0, have, e, b0.bus_rdata, b0.bus_err);
        p0 = b0.bus_ready;
    end

    always @(negedge clk) begin
        exp_t e;
        logic have;
        e = '{64'h0, 1'b0, 0};
        have = b1.bus_ready && q1.size() > 0;
        if (have) e = q1.pop_front();
        mon("d1", b1.bus_ready, p1, have, e, b1.bus_rdata, b1.bus_err);
        p1 = b1.bus_ready;
    end

    task automatic drive(input int d, input logic v, w, input logic [1:0] s, input logic [63:0] a, wd);
        if (d != 0) begin
            b1.bus_valid = v; b1.bus_wen = w; b1.bus_size = s; b1.bus_addr = a; b1.bus_wdata = wd;
        end else begin
            b0.bus_valid = v; b0.bus_wen = w; b0.bus_size = s; b0.bus_addr = a; b0.bus_wdata = wd;
        end
    endtask

    // Called at a negedge with the target idle; fields are scrambled after acceptance
    task automatic req(input int d, input logic w, input logic [1:0] s, input logic [63:0] a, wd,
                       input logic [63:0] rd, input logic er, input bit keep);
        int  lat;
        bit  got;
        lat = (d != 0) ? 4 : 1;
        got = 1'b0;
        drive(d, 1'b1, w, s, a, wd);
        if (d != 0) q1.push_back('{rd, er, cyc + lat}); else q0.push_back('{rd, er, cyc + lat});
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = (d != 0) ? b1.bus_ready : b0.bus_ready;
            if (i == 0 && !got) drive(d, 1'b1, ~w, ~s, a ^ 64'h40, ~wd);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL d%0d timeout addr=%h: no ready, want ready", d, a);
            if (d != 0) q1 = {}; else q0 = {};
        end
        if (!keep) drive(d, 1'b0, 1'b0, 2'd0, 64'h0, 64'h0);
        @(negedge clk);
    endtask

    initial begin
        rst0 = 1'b0;
        rst1 = 1'b0;
        drive(0, 1'b0, 1'b0, 2'd0, 64'h0, 64'h0);
        drive(1, 1'b0, 1'b0, 2'd0, 64'h0, 64'h0);
        repeat (3) @(negedge clk);
        rst0 = 1'b1;
        rst1 = 1'b1;

        // d0: LATENCY=1, out-of-range addresses wrap
        req(0, 1, 2'd3, 64'h0,    64'h0807060504030201, 64'h0, 0, 0);
        req(0, 0, 2'd3, 64'h0,    64'h0,                64'h0807060504030201, 0, 0);
        req(0, 1, 2'd3, 64'h2000, 64'h1122334455667788, 64'h0, 0, 0);
        req(0, 0, 2'd3, 64'h0,    64'h0,                64'h1122334455667788, 0, 0);
        req(0, 0, 2'd0, 64'h2003, 64'h0,                64'h55, 0, 0);
        req(0, 0, 2'd2, 64'h1,    64'h0,                64'h44556677, 0, 1);
        req(0, 0, 2'd1, 64'h6,    64'h0,                64'h1122, 0, 1);
        req(0, 1, 2'd3, 64'h1FFD, 64'hA1A2A3A4A5A6A7A8, 64'h0, 0, 1);
        req(0, 0, 2'd3, 64'h1FFD, 64'h0,                64'hA1A2A3A4A5A6A7A8, 0, 0);
        req(0, 0, 2'd0, 64'h4,    64'h0,                64'hA1, 0, 0);

        // d1: LATENCY=4, out-of-range addresses error
        req(1, 1, 2'd1, 64'h10,   64'hBEEF,             64'h0, 0, 0);
        req(1, 0, 2'd0, 64'h11,   64'h0,                64'hBE, 0, 0);
        req(1, 0, 2'd0, 64'h10,   64'h0,                64'hEF, 0, 0);
        req(1, 1, 2'd2, 64'h1FFE, 64'hAABBCCDD,         64'h0, 0, 0);
        req(1, 0, 2'd2, 64'h1FFE, 64'h0,                64'hAABBCCDD, 0, 0);
        req(1, 0, 2'd0, 64'h0,    64'h0,                64'hBB, 0, 0);
        req(1, 0, 2'd0, 64'h1,    64'h0,                64'hAA, 0, 0);
        req(1, 0, 2'd1, 64'h1FFF, 64'h0,                64'hBBCC, 0, 0);
        req(1, 1, 2'd3, 64'h0,    64'h0102030405060708, 64'h0, 0, 0);
        req(1, 1, 2'd3, 64'h2000, 64'hDEADBEEFCAFEF00D, 64'h0, 1, 0);
        req(1, 0, 2'd3, 64'h2008, 64'h0,                64'h0, 1, 0);
        req(1, 0, 2'd0, 64'h8000000000000000, 64'h0,    64'h0, 1, 0);
        req(1, 0, 2'd3, 64'h0,    64'h0,                64'h0102030405060708, 0, 0);

        // reset in WAIT aborts the write; first request after release is accepted at once
        drive(1, 1'b1, 1'b1, 2'd0, 64'h3, 64'h99);
        @(negedge clk);
        @(negedge clk);
        #2 rst1 = 1'b0;
        drive(1, 1'b0, 1'b0, 2'd0, 64'h0, 64'h0);
        @(negedge clk);
        rst1 = 1'b1;
        req(1, 0, 2'd0, 64'h3,    64'h0,                64'h05, 0, 0);

        req(1, 1, 2'd3, 64'h20,   64'h8877665544332211, 64'h0, 0, 1);
        req(1, 0, 2'd1, 64'h23,   64'h0,                64'h5544, 0, 1);
        req(1, 0, 2'd2, 64'h21,   64'h0,                64'h55443322, 0, 0);

        repeat (6) @(negedge clk);
        checks++;
        if (q0.size() + q1.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d responses missing, want 0", q0.size() + q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mp64_bus_ram.md
MP64_BUS_RAM -- requirements
Module: mp64_bus_ram

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 13, log2 of the memory size in bytes; legal range 10..20.
REQ-002 SHALL have parameter LATENCY, default 1, cycles from request acceptance to bus_ready; legal range 1..15.
REQ-003 SHALL have parameter ERR_ON_OOR, default 1; when 1, out-of-range accesses report an error; when 0, they wrap.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 bus_valid  input  1  request present; the master holds it until it samples bus_ready.
REQ-007 bus_addr  input  64  byte address.
REQ-008 bus_wdata  input  64  write data, little-endian, lane 0 = bits [7:0].
REQ-009 bus_wen  input  1  1 = write, 0 = read.
REQ-010 bus_size  input  2  access size from mp64_defs.vh: BUS_BYTE, BUS_HALF, BUS_WORD or BUS_DWORD (1/2/4/8 bytes).
REQ-011 bus_rdata  output  64  read data, zero-extended, valid only while bus_ready is 1.
REQ-012 bus_ready  output  1  single-cycle completion strobe.
REQ-013 bus_err  output  1  error strobe, asserted only together with bus_ready.

Function
REQ-014 Storage SHALL be a byte array of 2^ADDR_BITS entries; contents are not cleared by reset.
REQ-015 FSM states SHALL be IDLE, WAIT and RESP; the reset state is IDLE.
REQ-016 In IDLE with bus_valid=1, the block SHALL latch addr, wdata, wen and size, and load the wait counter with LATENCY-1.
- Counter = 0: go to RESP.
- Otherwise: go to WAIT.
REQ-017 In WAIT, the counter SHALL decrement each cycle; RESP is entered on the edge where the counter reaches 0.
- Result: bus_ready is high exactly LATENCY cycles after the acceptance edge.
- LATENCY=1 gives ready in the cycle immediately after valid is sampled.
REQ-018 The memory access SHALL be committed on the edge entering RESP.
- Write: write bytes at addresses A..A+n-1, taken from lanes 0..n-1 of the latched wdata.
- Read: register bus_rdata = {zeros, mem[A+n-1], ..., mem[A]}.
REQ-019 In RESP, bus_ready SHALL be 1 for exactly one cycle, then the FSM returns to IDLE.
- bus_valid is ignored in RESP.
- A new request can be accepted no earlier than the cycle after RESP.
REQ-020 bus_valid SHALL be ignored in WAIT; latched request fields SHALL NOT change after acceptance.
REQ-021 Outside RESP, bus_rdata SHALL be 0 and bus_ready = bus_err = 0.
- On a write response, bus_rdata SHALL be 0.
REQ-022 Byte addresses within an access SHALL be computed modulo 2^ADDR_BITS: an access crossing the top of memory wraps to address 0.
REQ-023 Out-of-range condition: bus_addr[63:ADDR_BITS] != 0.
- ERR_ON_OOR=1: the response carries bus_err=1, rdata=0, and no memory byte is modified.
- ERR_ON_OOR=0: only the low ADDR_BITS address bits are used, with no error.
REQ-024 Misaligned accesses SHALL be legal and complete with no error and no extra latency.
REQ-025 The implementation SHALL have no combinational path from any input to bus_ready, bus_rdata or bus_err.

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, counter=0, bus_ready=0, bus_err=0, bus_rdata=0.
REQ-027 Reset asserted while in WAIT SHALL abort the request: no write is committed and no response is issued after release.
REQ-028 After rst_n rises, the first request SHALL be accepted on the first rising edge at which bus_valid=1.

Verification
REQ-029 LATENCY=1, preload mem[0..7]=01..08, DWORD read at 0 -> ready 1 cycle after valid is sampled, rdata=0x0807060504030201, err=0.
REQ-030 LATENCY=4, HALF write 0xBEEF to 0x10, then BYTE read at 0x11 -> ready 4 cycles after each acceptance; read rdata=0x00000000000000BE; mem[0x10]=0xEF.
REQ-031 ADDR_BITS=13, WORD write 0xAABBCCDD to 0x1FFE -> mem[0x1FFE]=DD, mem[0x1FFF]=CC, mem[0x0000]=BB, mem[0x0001]=AA; err=0.
REQ-032 ERR_ON_OOR=1, DWORD write to 0x2000 -> ready=1, err=1, rdata=0, memory unchanged; same access with ERR_ON_OOR=0 -> writes at 0x0000, err=0.
REQ-033 LATENCY=8, write accepted, rst_n pulsed low at cycle 3 -> ready stays 0, target bytes keep their old value, the next read completes normally.
REQ-034 Back-to-back requests with valid held high through the RESP cycle -> exactly one response per request, and ready is never high on two consecutive cycles.
